// File: rtl/jt1943_rom_arb_if.sv
// jt1943_rom_arb_if: cache-side slot bus plus SDRAM read port shared by the ROM arbiter
interface jt1943_rom_arb_if #(parameter int AW = 22);
    logic            cen;
    logic [3:0]      slot_req;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]      slot_we;
    logic [31:0]     slot_dout;
    logic            sdram_req;
    logic [AW-2:0]   sdram_addr;
    logic            sdram_ack;
    logic            data_rdy;
    logic [31:0]     data_read;
    logic            timeout;
    modport master (
        input  cen, slot_req, slot_addr, sdram_ack, data_rdy, data_read,
        output slot_we, slot_dout, sdram_req, sdram_addr, timeout
    );
    modport slave (
        output cen, slot_req, slot_addr, sdram_ack, data_rdy, data_read,
        input  slot_we, slot_dout, sdram_req, sdram_addr, timeout
    );
endinterface

// File: rtl/jt1943_rom_arb.sv
// jt1943_rom_arb: four-slot round-robin SDRAM read arbiter; JT1943_ROMARB_TIMEOUT_EN adds a WAIT/DATA watchdog
module jt1943_rom_arb #(
    parameter int AW   = 22,
    parameter int TOUT = 255
) (
    input logic clk,
    input logic rst,
    jt1943_rom_arb_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DATA, DLVR} state_t;

    state_t        state_q, state_d;
    logic [1:0]    rr_q, rr_d;
    logic [1:0]    win_q, win_d;
    logic          req_q, req_d;
    logic [AW-2:0] addr_q, addr_d;
    logic [3:0]    we_q, we_d;
    logic [31:0]   dout_q, dout_d;
    logic [1:0]    pick;
    logic          abort;

    assign bus.sdram_req  = req_q;
    assign bus.sdram_addr = addr_q;
    assign bus.slot_we    = we_q;
    assign bus.slot_dout  = dout_q;

`ifdef JT1943_ROMARB_TIMEOUT_EN
    localparam int CW = TOUT > 255 ? $clog2(TOUT + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q;
    // Progress on the aborting edge wins over the watchdog
    assign abort = ((state_q == WAIT && !bus.sdram_ack) || (state_q == DATA && !bus.data_rdy))
                   && cnt_q == CW'(TOUT - 1);
    assign bus.timeout = timeout_q;
    // Held at zero in IDLE so every entry to WAIT starts a fresh count
    always_comb cnt_d = state_q == IDLE ? '0 : cnt_q + 1'b1;
    // Watchdog counter and one-cycle abort pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= abort;
        end
    end
`else
    assign abort       = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            dout_q  <= dout_d;
        end
    end

    // Round-robin pick and transaction sequencing
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        req_d   = req_q;
        addr_d  = addr_q;
        we_d    = we_q;
        dout_d  = dout_q;
        pick    = rr_q;
        for (int i = 3; i >= 0; i--)
            if (bus.slot_req[rr_q + 2'(i)]) pick = rr_q + 2'(i);
        case (state_q)
            IDLE: if (|bus.slot_req) begin
                win_d   = pick;
                rr_d    = pick + 2'd1;
                addr_d  = bus.slot_addr[32'(pick) * AW + 1 +: AW - 1];
                req_d   = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (bus.sdram_ack) begin
                req_d   = 1'b0;
                state_d = DATA;
                if (bus.data_rdy) begin
                    dout_d  = bus.data_read;
                    we_d    = 4'd1 << win_q;
                    state_d = DLVR;
                end
            end
            DATA: if (bus.data_rdy) begin
                dout_d  = bus.data_read;
                we_d    = 4'd1 << win_q;
                state_d = DLVR;
            end
            DLVR: if (bus.cen) begin
                we_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            req_d   = 1'b0;
            state_d = IDLE;
        end
    end
endmodule

// File: tb/tb_jt1943_rom_arb.sv
// tb_jt1943_rom_arb: directed self-checking bench for the ROM arbiter
module tb_jt1943_rom_arb;
    localparam int AW = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    jt1943_rom_arb_if #(.AW(AW)) bus ();

    jt1943_rom_arb #(.AW(AW), .TOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int n, input logic [AW-1:0] a);
        bus.slot_addr[n*AW +: AW] = a;
    endtask

    // Waits (bounded) for sdram_req at a negedge
    task automatic wait_req(input string tag);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.sdram_req) break;
        end
        if (k == 20) chk({tag, "_req_timeout"}, 64'(bus.sdram_req), 64'd1);
    endtask

    // Serves one transaction from WAIT: checks address, returns d, checks one-cycle delivery
    task automatic serve(input string tag, input logic [AW-2:0] exp_addr, input logic [3:0] exp_we,
                         input logic [31:0] d);
        wait_req(tag);
        chk({tag, "_addr"}, 64'(bus.sdram_addr), 64'(exp_addr));
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = d;
        step();
        bus.data_rdy  = 1'b0;
        @(negedge clk);
        chk({tag, "_we"}, 64'(bus.slot_we), 64'(exp_we));
        chk({tag, "_dout"}, 64'(bus.slot_dout), 64'(d));
        @(negedge clk);
        chk({tag, "_we_clr"}, 64'(bus.slot_we), 64'd0);
    endtask

    initial begin
        int n;
        bus.cen       = 1'b1;
        bus.slot_req  = '0;
        bus.slot_addr = '0;
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        bus.data_read = '0;
        for (int i = 0; i < 4; i++) set_addr(i, AW'((i + 1) * 'h100));

        // Reset values
        step();
        step();
        @(negedge clk);
        chk("rst_req", 64'(bus.sdram_req), 64'd0);
        chk("rst_addr", 64'(bus.sdram_addr), 64'd0);
        chk("rst_we", 64'(bus.slot_we), 64'd0);
        chk("rst_dout", 64'(bus.slot_dout), 64'd0);
        chk("rst_timeout", 64'(bus.timeout), 64'd0);
        step();
        rst = 1'b0;

        // 1: slot 2 at byte 0x104 -> word 0x82, delivers DEADBEEF
        step();
        set_addr(2, 22'h00104);
        bus.slot_req = 4'b0100;
        @(negedge clk);
        chk("t1_req_pre", 64'(bus.sdram_req), 64'd0);
        @(negedge clk);
        chk("t1_req_1cyc", 64'(bus.sdram_req), 64'd1);
        bus.slot_req = 4'b0000;
        serve("t1", 21'h00082, 4'b0100, 32'hDEADBEEF);
        set_addr(2, 22'h300);

        // 2: all slots requesting from reset -> order 0,1,2,3,0
        step();
        rst = 1'b1;
        bus.slot_req = 4'b1111;
        step();
        rst = 1'b0;
        serve("t2_s0", 21'h080, 4'b0001, 32'hA0A0_0000);
        serve("t2_s1", 21'h100, 4'b0010, 32'hA1A1_1111);
        serve("t2_s2", 21'h180, 4'b0100, 32'hA2A2_2222);
        serve("t2_s3", 21'h200, 4'b1000, 32'hA3A3_3333);
        serve("t2_s0b", 21'h080, 4'b0001, 32'hA4A4_4444);
        bus.slot_req = 4'b0000;

        // 3: cen low 5 cycles in DLVR -> slot_we high 6 cycles
        step();
        step();
        step();
        bus.slot_req = 4'b0010;
        wait_req("t3");
        bus.slot_req  = 4'b0000;
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'hCAFE_F00D;
        bus.cen       = 1'b0;
        step();
        bus.data_rdy = 1'b0;
        n = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (bus.slot_we == 4'b0010) n++;
            step();
        end
        bus.cen = 1'b1;
        @(negedge clk);
        if (bus.slot_we == 4'b0010) n++;
        chk("t3_we_cycles", 64'(n), 64'd6);
        @(negedge clk);
        chk("t3_we_clr", 64'(bus.slot_we), 64'd0);

        // 4: reset in DATA, late data_rdy ignored, next request served
        step();
        bus.slot_req = 4'b1000;
        wait_req("t4");
        bus.slot_req  = 4'b0000;
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_req", 64'(bus.sdram_req), 64'd0);
        step();
        rst = 1'b0;
        step();
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'hBAD0_BAD0;
        step();
        bus.data_rdy = 1'b0;
        @(negedge clk);
        chk("t4_we", 64'(bus.slot_we), 64'd0);
        chk("t4_dout", 64'(bus.slot_dout), 64'd0);
        chk("t4_idle", 64'(bus.sdram_req), 64'd0);
        step();
        bus.slot_req = 4'b0001;
        serve("t4_next", 21'h080, 4'b0001, 32'h0BAD_CAFE);
        bus.slot_req = 4'b0000;

        // 5: ack and data_rdy in the same cycle
        step();
        step();
        bus.slot_req = 4'b0010;
        wait_req("t5");
        bus.slot_req  = 4'b0000;
        bus.sdram_ack = 1'b1;
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h12345678;
        step();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        @(negedge clk);
        chk("t5_we", 64'(bus.slot_we), 64'b0010);
        chk("t5_dout", 64'(bus.slot_dout), 64'h12345678);
        chk("t5_req", 64'(bus.sdram_req), 64'd0);
        @(negedge clk);
        chk("t5_we_clr", 64'(bus.slot_we), 64'd0);

        // 6: never ack
        step();
        bus.slot_req = 4'b0001;
        wait_req("t6");
        bus.slot_req = 4'b0000;
`ifdef JT1943_ROMARB_TIMEOUT_EN
        n = 1;
        for (int j = 0; j < 400 && bus.sdram_req; j++) begin
            @(negedge clk);
            if (bus.sdram_req) n++;
        end
        chk("t6_req_cycles", 64'(n), 64'd255);
        chk("t6_timeout_hi", 64'(bus.timeout), 64'd1);
        @(negedge clk);
        chk("t6_timeout_lo", 64'(bus.timeout), 64'd0);
        chk("t6_we", 64'(bus.slot_we), 64'd0);
`else
        for (int j = 0; j < 300; j++) @(negedge clk);
        chk("t6_req_held", 64'(bus.sdram_req), 64'd1);
        chk("t6_timeout", 64'(bus.timeout), 64'd0);
        chk("t6_we", 64'(bus.slot_we), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
